if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/rv_fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 55 +++++
 rtl/if_fetch_unit.sv | 136 +++++++++++++
 tb/tb_if_fetch_unit.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and constants for the instruction fetch unit.
package rv_fetch_pkg;

   // Fetch unit control states; RUN is the reset state.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FAULT = 2'd1,
      ST_IDLE  = 2'd2
   } fetch_state_t;

   // Default queue depth, which is also the in-flight credit limit.
   localparam int QDEPTH_DEFAULT = 2;

   // addi x0, x0, 0 -- instruction slot presented alongside a fetch fault.
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // Sequential PC step; wraps naturally at 32'hFFFFFFFC -> 0.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of {pc, instr} entries with flush and occupancy count.
module fetch_queue #(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  logic [63:0]                    push_data,
   input  logic                           pop,
   output logic [63:0]                    head,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + AW'(1);
   endfunction

   // Full/empty guards keep the pointers consistent even on a misbehaving caller.
   always_comb begin
      do_push = push && (count != FULL);
      do_pop  = pop && (count != '0);
   end

   // Pointer and occupancy update; flush empties the queue in one cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: credit-limited instruction fetch with redirect, stale-response
// discard and a misaligned-target fault slot toward the IF/ID register.
//
// Handshakes: a fetch request transfers on any rising edge where
// imem_req_valid && imem_req_ready; once raised, imem_req_valid/imem_req_addr
// hold until the transfer except in a redirect cycle. Responses are valid-only
// (no backpressure), in order. The decode side transfers on if_valid && id_ready.
module if_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000,
   parameter int          QDEPTH       = QDEPTH_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   output logic         imem_req_valid,
   input  logic         imem_req_ready,
   output logic [31:0]  imem_req_addr,
   input  logic         imem_rsp_valid,
   input  logic [31:0]  imem_rsp_data,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   input  logic         id_ready,
   output logic         if_valid,
   output logic [31:0]  if_pc,
   output logic [31:0]  if_instr,
   output logic         if_fault,
   output fetch_state_t dbg_state
);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0] QD_W = QDEPTH[CW:0];

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, rsp_pc_q, fault_pc_q;
   logic [CW-1:0] outstanding_q, outstanding_d, discard_q;
   logic [CW-1:0] q_count;
   logic [63:0]   q_head;
   logic [CW:0]   inflight;
   logic          req_fire, rsp_fire, rsp_drop, rsp_keep;
   logic          q_push, q_pop, q_flush;

   fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (q_flush),
      .push      (q_push),
      .push_data ({rsp_pc_q, imem_rsp_data}),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count)
   );

   // Memory-side bookkeeping: credit check, transfers, response routing.
   always_comb begin
      inflight       = {1'b0, outstanding_q} + {1'b0, q_count};
      imem_req_valid = !reset && (state_q == ST_RUN) && !redirect_valid && (inflight < QD_W);
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_fire       = !reset && imem_rsp_valid;
      rsp_drop       = rsp_fire && (discard_q != '0);
      rsp_keep       = rsp_fire && (discard_q == '0);
      outstanding_d  = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
      q_flush        = redirect_valid;
      q_push         = rsp_keep && !redirect_valid;
   end

   // Decode-side outputs per state; everything reads as zero while in reset.
   always_comb begin
      if_valid = 1'b0;
      if_pc    = '0;
      if_instr = '0;
      if_fault = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_RUN: begin
               if_valid = (q_count != '0);
               if (if_valid) begin
                  if_pc    = q_head[63:32];
                  if_instr = q_head[31:0];
               end
            end
            ST_FAULT: begin
               if_valid = 1'b1;
               if_fault = 1'b1;
               if_pc    = fault_pc_q;
               if_instr = NOP_INSTR;
            end
            default: ;
         endcase
      end
      q_pop = if_valid && id_ready && (state_q == ST_RUN) && !redirect_valid;
   end

   // Next state: redirect wins; a consumed fault slot parks the unit in IDLE.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
      end else if ((state_q == ST_FAULT) && id_ready) begin
         state_d = ST_IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // PCs and credit counters; a redirect turns every remaining in-flight
   // response (after this cycle's one) into a discard.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_VECTOR;
         rsp_pc_q      <= RESET_VECTOR;
         fault_pc_q    <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            rsp_pc_q   <= redirect_pc;
            fault_pc_q <= redirect_pc;
            discard_q  <= outstanding_d;
         end else begin
            if (req_fire) fetch_pc_q <= next_pc(fetch_pc_q);
            if (rsp_keep) rsp_pc_q   <= next_pc(rsp_pc_q);
            if (rsp_drop) discard_q  <= discard_q - CW'(1);
         end
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus randomized traffic, checked against
// a program-stream model: after reset/redirect to P, requests must go out as
// P, P+4, ... and decode must see exactly those PCs in order with memory data.
module tb_if_fetch_unit;
   import rv_fetch_pkg::*;

   localparam logic [31:0] RV = 32'h00000000;
   localparam int          QD = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         imem_req_valid;
   logic         imem_req_ready;
   logic [31:0]  imem_req_addr;
   logic         imem_rsp_valid;
   logic [31:0]  imem_rsp_data;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         id_ready;
   logic         if_valid;
   logic [31:0]  if_pc;
   logic [31:0]  if_instr;
   logic         if_fault;
   fetch_state_t dbg_state;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state.
   fetch_state_t mode;
   logic [31:0]  exp_req;
   logic [31:0]  fault_pc;
   logic [31:0]  exp_q[$];      // live accepted requests not yet consumed, in order
   int           live_ready;    // how many of exp_q have already returned
   logic [31:0]  pend_addr[$];  // memory model: requests awaiting response
   int           pend_due[$];
   bit           pend_live[$];
   int           cyc      = 0;
   int           last_due = 0;
   int           lat_min  = 1;
   int           lat_max  = 1;
   logic [31:0]  acc_log[$];
   logic [31:0]  pop_log[$];

   if_fetch_unit #(.RESET_VECTOR(RV), .QDEPTH(QD)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_fault       (if_fault),
      .dbg_state      (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
   endfunction

   function automatic int stale_cnt();
      int n = 0;
      foreach (pend_live[i]) if (!pend_live[i]) n++;
      return n;
   endfunction

   // One clock cycle: drive memory response, check outputs, advance model.
   // Called at a falling edge with the other inputs already set.
   task automatic step();
      bit          rsp_v;
      bit          rsp_live;
      logic [31:0] rsp_a;
      bit          acc;
      bit          exp_v;
      int          lat;
      int          due;
      cyc++;
      rsp_v    = 1'b0;
      rsp_live = 1'b0;
      rsp_a    = '0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         rsp_v    = 1'b1;
         rsp_a    = pend_addr[0];
         rsp_live = pend_live[0];
      end
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_v ? memfn(rsp_a) : $urandom();
      #1;
      acc = imem_req_valid && imem_req_ready;
      if (reset) begin
         n_total++;
         if ({imem_req_valid, if_valid, if_fault, if_pc, if_instr} !== 66'd0)
            $display("FAIL reset_outputs cyc=%0d got req_v=%0b if_v=%0b fault=%0b pc=%h instr=%h want all zero",
                     cyc, imem_req_valid, if_valid, if_fault, if_pc, if_instr);
         else n_pass++;
      end else begin
         exp_v = (mode == ST_RUN) && !redirect_valid && (exp_q.size() + stale_cnt() < QD);
         n_total++;
         if (imem_req_valid !== exp_v)
            $display("FAIL req_valid cyc=%0d got=%0b want=%0b", cyc, imem_req_valid, exp_v);
         else n_pass++;
         if (imem_req_valid) begin
            n_total++;
            if (imem_req_addr !== exp_req)
               $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, exp_req);
            else n_pass++;
         end
         n_total++;
         if (dbg_state !== mode)
            $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, dbg_state, mode);
         else n_pass++;
         case (mode)
            ST_RUN: begin
               n_total++;
               if (if_valid !== (live_ready > 0))
                  $display("FAIL if_valid cyc=%0d got=%0b want=%0b", cyc, if_valid, live_ready > 0);
               else n_pass++;
               if (live_ready > 0) begin
                  n_total++;
                  if ({if_fault, if_pc, if_instr} !== {1'b0, exp_q[0], memfn(exp_q[0])})
                     $display("FAIL if_head cyc=%0d got fault=%0b pc=%h instr=%h want fault=0 pc=%h instr=%h",
                              cyc, if_fault, if_pc, if_instr, exp_q[0], memfn(exp_q[0]));
                  else n_pass++;
               end
            end
            ST_FAULT: begin
               n_total++;
               if ({if_valid, if_fault, if_pc, if_instr} !== {1'b1, 1'b1, fault_pc, 32'h00000013})
                  $display("FAIL fault_slot cyc=%0d got v=%0b f=%0b pc=%h instr=%h want v=1 f=1 pc=%h instr=00000013",
                           cyc, if_valid, if_fault, if_pc, if_instr, fault_pc);
               else n_pass++;
            end
            default: begin
               n_total++;
               if ({if_valid, if_fault} !== 2'b00)
                  $display("FAIL idle_out cyc=%0d got v=%0b f=%0b want 0 0", cyc, if_valid, if_fault);
               else n_pass++;
            end
         endcase
      end
      // advance model to the state after this edge
      if (rsp_v) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
         void'(pend_live.pop_front());
      end
      if (reset) begin
         mode       = ST_RUN;
         exp_req    = RV;
         fault_pc   = '0;
         live_ready = 0;
         exp_q.delete();
         pend_addr.delete();
         pend_due.delete();
         pend_live.delete();
         last_due   = cyc;
      end else if (redirect_valid) begin
         mode       = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
         fault_pc   = redirect_pc;
         exp_req    = redirect_pc;
         live_ready = 0;
         exp_q.delete();
         foreach (pend_live[i]) pend_live[i] = 1'b0;
      end else begin
         if (mode == ST_RUN && live_ready > 0 && id_ready) begin
            pop_log.push_back(exp_q[0]);
            void'(exp_q.pop_front());
            live_ready--;
         end
         if (rsp_v && rsp_live) live_ready++;
         if (acc) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(exp_req);
            pend_due.push_back(due);
            pend_live.push_back(1'b1);
            exp_q.push_back(exp_req);
            acc_log.push_back(exp_req);
            exp_req = exp_req + 32'd4;
         end
         if (mode == ST_FAULT && id_ready) mode = ST_IDLE;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset(input int n);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) step();
      n_total++;
      if ({imem_req_valid, if_valid, if_fault, if_pc, if_instr} !== 66'd0)
         $display("FAIL rst_hold got req_v=%0b if_v=%0b pc=%h want zeros", imem_req_valid, if_valid, if_pc);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, RV})
         $display("FAIL rst_first_req got v=%0b addr=%h want v=1 addr=%h", imem_req_valid, imem_req_addr, RV);
      else n_pass++;
      step();
   endtask

   task automatic test_basic();
      logic [31:0] got;
      apply_reset(2);
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      acc_log.delete();
      pop_log.delete();
      repeat (12) step();
      for (int i = 0; i < 3; i++) begin
         got = (i < acc_log.size()) ? acc_log[i] : 32'hxxxxxxxx;
         n_total++;
         if (got !== RV + 32'(4 * i)) $display("FAIL basic_req%0d got=%h want=%h", i, got, RV + 32'(4 * i));
         else n_pass++;
         got = (i < pop_log.size()) ? pop_log[i] : 32'hxxxxxxxx;
         n_total++;
         if (got !== RV + 32'(4 * i)) $display("FAIL basic_pop%0d got=%h want=%h", i, got, RV + 32'(4 * i));
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      logic [31:0] got;
      apply_reset(2);
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      acc_log.delete();
      pop_log.delete();
      repeat (5) step();
      n_total++;
      if ({if_valid, if_pc} !== {1'b1, 32'h0}) $display("FAIL stall_head got v=%0b pc=%h want v=1 pc=0", if_valid, if_pc);
      else n_pass++;
      n_total++;
      if ((acc_log.size() <= 2) !== 1'b1) $display("FAIL stall_reqs got=%0d want<=2", acc_log.size());
      else n_pass++;
      n_total++;
      if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid got=%0b want=0", imem_req_valid);
      else n_pass++;
      id_ready = 1'b1;
      repeat (8) step();
      for (int i = 0; i < 2; i++) begin
         got = (i < pop_log.size()) ? pop_log[i] : 32'hxxxxxxxx;
         n_total++;
         if (got !== 32'(4 * i)) $display("FAIL stall_resume%0d got=%h want=%h", i, got, 32'(4 * i));
         else n_pass++;
      end
   endtask

   task automatic test_redirect();
      logic [31:0] got;
      int          bad;
      apply_reset(2);
      lat_min = 3; lat_max = 3;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      acc_log.delete();
      repeat (2) step();
      n_total++;
      if (acc_log.size() !== 2) $display("FAIL redir_inflight got=%0d want=2", acc_log.size());
      else n_pass++;
      pop_log.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      lat_min = 1; lat_max = 1;
      repeat (12) step();
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxxxxxx;
      n_total++;
      if (got !== 32'h100) $display("FAIL redir_first got=%h want=00000100", got);
      else n_pass++;
      bad = 0;
      foreach (pop_log[i]) if (pop_log[i] == 32'h4 || pop_log[i] == 32'h8) bad++;
      n_total++;
      if (bad !== 0) $display("FAIL redir_stale got=%0d stale pops want=0", bad);
      else n_pass++;
   endtask

   task automatic test_misaligned();
      int viol;
      apply_reset(2);
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      step();
      redirect_valid = 1'b0;
      #1;
      n_total++;
      if ({imem_req_valid, if_valid, if_fault, if_pc, if_instr} !== {1'b0, 1'b1, 1'b1, 32'h102, 32'h00000013})
         $display("FAIL misal_slot got req_v=%0b v=%0b f=%0b pc=%h instr=%h want 0 1 1 00000102 00000013",
                  imem_req_valid, if_valid, if_fault, if_pc, if_instr);
      else n_pass++;
      repeat (2) step();
      id_ready = 1'b1;
      step();
      viol = 0;
      repeat (4) begin
         step();
         if (if_valid || imem_req_valid) viol++;
      end
      n_total++;
      if (viol !== 0) $display("FAIL misal_idle got=%0d active cycles want=0", viol);
      else n_pass++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_valid = 1'b0;
      #1;
      n_total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200})
         $display("FAIL redir_n1 got v=%0b addr=%h want v=1 addr=00000200", imem_req_valid, imem_req_addr);
      else n_pass++;
      step();
      n_total++;
      if (if_valid !== 1'b0) $display("FAIL redir_n2 got if_valid=%0b want=0", if_valid);
      else n_pass++;
      step();
      n_total++;
      if ({if_valid, if_pc} !== {1'b1, 32'h200}) $display("FAIL redir_n3 got v=%0b pc=%h want v=1 pc=00000200", if_valid, if_pc);
      else n_pass++;
      repeat (3) step();
   endtask

   task automatic test_req_stall();
      logic [31:0] got;
      apply_reset(2);
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid && imem_req_addr == 32'h8) break;
         step();
      end
      n_total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8})
         $display("FAIL hold_reach got v=%0b addr=%h want v=1 addr=00000008", imem_req_valid, imem_req_addr);
      else n_pass++;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8})
            $display("FAIL hold_addr%0d got v=%0b addr=%h want v=1 addr=00000008", i, imem_req_valid, imem_req_addr);
         else n_pass++;
      end
      pop_log.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      #1;
      n_total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h40})
         $display("FAIL hold_redir got v=%0b addr=%h want v=1 addr=00000040", imem_req_valid, imem_req_addr);
      else n_pass++;
      imem_req_ready = 1'b1;
      repeat (6) step();
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxxxxxx;
      n_total++;
      if (got !== 32'h40) $display("FAIL hold_pop got=%h want=00000040", got);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [31:0] got;
      logic [31:0] want;
      apply_reset(2);
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      repeat (3) step();
      acc_log.delete();
      pop_log.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFFFFFC;
      step();
      redirect_valid = 1'b0;
      repeat (10) step();
      for (int i = 0; i < 2; i++) begin
         want = (i == 0) ? 32'hFFFFFFFC : 32'h00000000;
         got  = (i < acc_log.size()) ? acc_log[i] : 32'hxxxxxxxx;
         n_total++;
         if (got !== want) $display("FAIL wrap_req%0d got=%h want=%h", i, got, want);
         else n_pass++;
         got = (i < pop_log.size()) ? pop_log[i] : 32'hxxxxxxxx;
         n_total++;
         if (got !== want) $display("FAIL wrap_pop%0d got=%h want=%h", i, got, want);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int          r;
      logic [31:0] rp;
      apply_reset(2);
      lat_min = 1; lat_max = 3;
      pop_log.delete();
      for (int i = 0; i < 800; i++) begin
         r  = $urandom_range(0, 99);
         rp = $urandom();
         if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
         imem_req_ready = ($urandom_range(0, 3) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = (r < 4);
         redirect_pc    = rp;
         reset          = (r == 99);
         step();
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      repeat (10) step();
      n_total++;
      if ((pop_log.size() > 10) !== 1'b1) $display("FAIL rand_progress got=%0d pops want>10", pop_log.size());
      else n_pass++;
   endtask

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      mode           = ST_RUN;
      exp_req        = RV;
      fault_pc       = '0;
      live_ready     = 0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_misaligned();
      test_req_stall();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
